// File: rtl/sc_param.sv
// Up/down counter with saturate-or-wrap bounds, synchronous load and clear,
// tracked by a ZERO/MID/TOP state machine that flags bad loads and corruption.
module sc_param #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned MAX   = 5,
    parameter bit          WRAP  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctr_rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             sat_hi,
    output logic             sat_lo,
    output logic             err
);

    typedef enum logic [1:0] {
        ZERO = 2'b00,
        MID  = 2'b01,
        TOP  = 2'b10
    } state_e;

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             bad;

    function automatic state_e state_of(input logic [WIDTH-1:0] c);
        if (c == '0)         return ZERO;
        else if (c == MAX_V) return TOP;
        else                 return MID;
    endfunction

    // State is redundant with the count; any disagreement (including the
    // unused encoding) or an out-of-range count is treated as corruption.
    assign bad = (state_q != state_of(cnt_q)) || (cnt_q > MAX_V);

    always_comb begin
        cnt_d = cnt_q;
        err_d = 1'b0;
        if (bad) begin
            cnt_d = '0;
            err_d = 1'b1;
        end else if (ctr_rst) begin
            cnt_d = '0;
        end else if (load) begin
            if (load_val <= MAX_V) cnt_d = load_val;
            else                   err_d = 1'b1;
        end else if (en) begin
            if (dir) begin
                if (cnt_q < MAX_V) cnt_d = cnt_q + WIDTH'(1);
                else if (WRAP)     cnt_d = '0;
            end else begin
                if (cnt_q != '0)   cnt_d = cnt_q - WIDTH'(1);
                else if (WRAP)     cnt_d = MAX_V;
            end
        end
        state_d = state_of(cnt_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ZERO;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign out    = cnt_q;
    assign sat_lo = (state_q == ZERO);
    assign sat_hi = (state_q == TOP);
    assign err    = err_q;

endmodule
